enemy_controller: RTL

ENEMY_CONTROLLER -- requirements
Module: enemy_controller

---
 rtl/enemy_controller.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/enemy_controller.sv
// Single-enemy state machine: spawn, per-frame motion, hit/flash handling, kill and escape.
// The enemy type output is named enemy_type because `type` is a reserved word in SystemVerilog.
module enemy_controller #(
    parameter logic [9:0] X_MIN        = 10'd8,
    parameter logic [9:0] X_MAX        = 10'd631,
    parameter logic [9:0] Y_MAX        = 10'd471,
    parameter logic [3:0] FLASH_FRAMES = 4'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       spawn_req,
    input  logic [1:0] spawn_type,
    input  logic [9:0] spawn_x,
    input  logic [9:0] spawn_y,
    output logic       spawn_ack,
    input  logic       hit,
    output logic [1:0] enemy_type,
    output logic [3:0] health,
    output logic [9:0] x_mid,
    output logic [9:0] y_mid,
    output logic       alive,
    output logic       killed,
    output logic       escaped
);

    typedef enum logic [1:0] {IDLE, ALIVE, FLASH} state_t;

    state_t      state, state_nxt;
    logic        dir_right, dir_nxt;
    logic [3:0]  flash_cnt, flash_nxt;
    logic [1:0]  type_nxt;
    logic [3:0]  health_nxt;
    logic [9:0]  x_nxt, y_nxt;
    logic        ack_nxt, killed_nxt, escaped_nxt;

    logic [1:0]  y_step;
    logic [10:0] y_sum;
    logic [9:0]  y_mv, x_mv;
    logic        dir_mv, escape;

    // Candidate motion for this tick; only committed when frame_tick is high.
    always_comb begin
        case (enemy_type)
            2'd0:    y_step = 2'd3;
            2'd1:    y_step = 2'd2;
            default: y_step = 2'd1;
        endcase
        y_sum = {1'b0, y_mid} + {9'd0, y_step};
        y_mv  = y_sum[10] ? 10'h3FF : y_sum[9:0];
        if (x_mid >= X_MAX) begin
            dir_mv = 1'b0;
            x_mv   = X_MAX - 10'd1;
        end else if (x_mid <= X_MIN) begin
            dir_mv = 1'b1;
            x_mv   = X_MIN + 10'd1;
        end else begin
            dir_mv = dir_right;
            x_mv   = dir_right ? x_mid + 10'd1 : x_mid - 10'd1;
        end
        escape = frame_tick && (y_mv >= Y_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (spawn_req && spawn_type != 2'd3) state_nxt = ALIVE;
            ALIVE: begin
                if (escape)   state_nxt = IDLE;
                else if (hit) state_nxt = (health <= 4'd1) ? IDLE : FLASH;
            end
            FLASH: begin
                if (escape)                               state_nxt = IDLE;
                else if (frame_tick && flash_cnt <= 4'd1) state_nxt = ALIVE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of every registered output; escape beats a same-cycle hit.
    always_comb begin
        type_nxt    = enemy_type;
        health_nxt  = health;
        x_nxt       = x_mid;
        y_nxt       = y_mid;
        dir_nxt     = dir_right;
        flash_nxt   = flash_cnt;
        ack_nxt     = 1'b0;
        killed_nxt  = 1'b0;
        escaped_nxt = 1'b0;
        if (state == IDLE) begin
            if (spawn_req && spawn_type != 2'd3) begin
                type_nxt  = spawn_type;
                x_nxt     = spawn_x;
                y_nxt     = spawn_y;
                dir_nxt   = 1'b1;
                flash_nxt = 4'd0;
                ack_nxt   = 1'b1;
                case (spawn_type)
                    2'd0:    health_nxt = 4'd1;
                    2'd1:    health_nxt = 4'd3;
                    default: health_nxt = 4'd4;
                endcase
            end
        end else begin
            if (frame_tick) begin
                y_nxt = y_mv;
                if (enemy_type == 2'd1) begin
                    x_nxt   = x_mv;
                    dir_nxt = dir_mv;
                end
            end
            if (escape) begin
                escaped_nxt = 1'b1;
                flash_nxt   = 4'd0;
            end else if (state == ALIVE && hit) begin
                if (health <= 4'd1) begin
                    health_nxt = 4'd0;
                    killed_nxt = 1'b1;
                end else begin
                    health_nxt = health - 4'd1;
                    flash_nxt  = FLASH_FRAMES;
                end
            end else if (state == FLASH && frame_tick) begin
                flash_nxt = (flash_cnt <= 4'd1) ? 4'd0 : flash_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enemy_type <= 2'd0;
            health     <= 4'd0;
            x_mid      <= 10'd0;
            y_mid      <= 10'd0;
            dir_right  <= 1'b1;
            flash_cnt  <= 4'd0;
            alive      <= 1'b0;
            spawn_ack  <= 1'b0;
            killed     <= 1'b0;
            escaped    <= 1'b0;
        end else begin
            enemy_type <= type_nxt;
            health     <= health_nxt;
            x_mid      <= x_nxt;
            y_mid      <= y_nxt;
            dir_right  <= dir_nxt;
            flash_cnt  <= flash_nxt;
            alive      <= (state_nxt != IDLE);
            spawn_ack  <= ack_nxt;
            killed     <= killed_nxt;
            escaped    <= escaped_nxt;
        end
    end

endmodule
